// File: rtl/apb_stream_irq_regs.sv
// ---------------------------------------------------------------------------
// apb_stream_irq_regs
//
// APB register slave combining a W1C interrupt block with valid/ready stream
// ports. Accesses to the stream data registers stall the APB bus with PREADY
// wait states until the core side handshakes. A bounded wait counter ends any
// stall with an error response.
//
// Register map (byte addresses):
//   0x00 IRQ_STATUS     W1C, NUM_IRQ bits, set by synchronised rising edges
//   0x04 IRQ_ENABLE     RW,  NUM_IRQ bits
//   0x08 IRQ_SET        WO,  writing 1 sets the matching status bit
//   0x0C WR_DATA        WO,  write pushes PWDATA onto the write stream
//   0x10 RD_DATA        RO,  read pops one word from the read stream
//   0x14 STREAM_STATUS  RO,  [0] wr_ready, [1] rd_valid, [15:8] TO_CNT;
//                            any write clears TO_CNT
//
// Ports:
//   RegClk, RegReset          clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA    APB request
//   PRDATA/PREADY/PSLVERR     APB response (combinational from the bus)
//   irq_in                    asynchronous interrupt sources (edge detected)
//   irq                       registered aggregate interrupt
//   wr_data/wr_valid/wr_ready write stream towards the core
//   rd_data/rd_valid/rd_ready read stream from the core
// ---------------------------------------------------------------------------
module apb_stream_irq_regs #(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_IRQ     = 8,
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic                   RegClk,
    input  logic                   RegReset,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDR_WIDTH-1:0]  PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic [NUM_IRQ-1:0]     irq_in,
    output logic                   irq,
    output logic [WDATA_WIDTH-1:0] wr_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    input  logic [RDATA_WIDTH-1:0] rd_data,
    input  logic                   rd_valid,
    output logic                   rd_ready
);

    // -----------------------------------------------------------------------
    // Address map
    // -----------------------------------------------------------------------
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_STATUS    = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_ENABLE    = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_SET       = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_WR_DATA       = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RD_DATA       = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STREAM_STATUS = ADDR_WIDTH'('h14);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] TO_CNT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        SEL_IRQ_STATUS,
        SEL_IRQ_ENABLE,
        SEL_IRQ_SET,
        SEL_WR_DATA,
        SEL_RD_DATA,
        SEL_STREAM_STATUS,
        SEL_NONE
    } reg_sel_e;

    // -----------------------------------------------------------------------
    // Internal signals
    // -----------------------------------------------------------------------
    reg_sel_e           reg_sel;
    logic               access;
    logic               wr_stall;
    logic               rd_stall;
    logic               timeout;
    logic               complete;
    logic               reg_wr;
    logic               to_cnt_clr;
    logic [7:0]         wait_cnt;
    logic [7:0]         to_cnt;

    logic [NUM_IRQ-1:0] irq_meta;
    logic [NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0] irq_dly;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] irq_status;
    logic [NUM_IRQ-1:0] irq_status_nxt;
    logic [NUM_IRQ-1:0] irq_enable;
    logic [NUM_IRQ-1:0] set_bits;
    logic [NUM_IRQ-1:0] w1c_bits;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        reg_sel = SEL_NONE;
        case (PADDR)
            ADDR_IRQ_STATUS:    reg_sel = SEL_IRQ_STATUS;
            ADDR_IRQ_ENABLE:    reg_sel = SEL_IRQ_ENABLE;
            ADDR_IRQ_SET:       reg_sel = SEL_IRQ_SET;
            ADDR_WR_DATA:       reg_sel = SEL_WR_DATA;
            ADDR_RD_DATA:       reg_sel = SEL_RD_DATA;
            ADDR_STREAM_STATUS: reg_sel = SEL_STREAM_STATUS;
            default:            reg_sel = SEL_NONE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Transfer control
    // -----------------------------------------------------------------------
    assign access   = PSEL & PENABLE;
    assign wr_stall = access &  PWRITE & (reg_sel == SEL_WR_DATA);
    assign rd_stall = access & ~PWRITE & (reg_sel == SEL_RD_DATA);

    // Timeout is evaluated before the handshake: a stream partner that becomes
    // ready in the same cycle the budget runs out does not get the transfer.
    assign timeout  = (wr_stall | rd_stall) & (wait_cnt == TIMEOUT_CNT);

    always_comb begin
        PREADY = 1'b1;
        if (wr_stall) begin
            PREADY = wr_ready | timeout;
        end else if (rd_stall) begin
            PREADY = rd_valid | timeout;
        end
    end

    assign complete = access & PREADY;
    assign reg_wr   = complete & PWRITE;

    // The bus-facing outputs are combinational from the bus, so they are
    // forced to their idle values while reset is asserted; otherwise a reset
    // during an open access phase would keep presenting a push or pop.
    assign wr_valid = wr_stall & ~timeout & ~RegReset;
    assign wr_data  = wr_valid ? PWDATA[WDATA_WIDTH-1:0] : '0;
    assign rd_ready = rd_stall & ~timeout & ~RegReset;
    assign PSLVERR  = complete & ((reg_sel == SEL_NONE) | timeout) & ~RegReset;

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE && !timeout && !RegReset) begin
            case (reg_sel)
                SEL_IRQ_STATUS:    PRDATA[NUM_IRQ-1:0] = irq_status;
                SEL_IRQ_ENABLE:    PRDATA[NUM_IRQ-1:0] = irq_enable;
                SEL_RD_DATA:       PRDATA[RDATA_WIDTH-1:0] = rd_data;
                SEL_STREAM_STATUS: begin
                    PRDATA[0]    = wr_ready;
                    PRDATA[1]    = rd_valid;
                    PRDATA[15:8] = to_cnt;
                end
                default:           PRDATA = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Wait counter: counts stalled access cycles of the current transfer.
    // -----------------------------------------------------------------------
    always_ff @(posedge RegClk or posedge RegReset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values, independent of process evaluation order.
        if (RegReset) begin
            wait_cnt <= '0;
        end else if (!PSEL || complete) begin
            wait_cnt <= '0;
        end else if (access) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Timeout event counter, saturating; a clearing write wins over a
    // timeout landing in the same cycle.
    // -----------------------------------------------------------------------
    assign to_cnt_clr = reg_wr & (reg_sel == SEL_STREAM_STATUS);

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            to_cnt <= '0;
        end else if (to_cnt_clr) begin
            to_cnt <= '0;
        end else if (timeout && (to_cnt != TO_CNT_MAX)) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt enable register
    // -----------------------------------------------------------------------
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            irq_enable <= '0;
        end else if (reg_wr && (reg_sel == SEL_IRQ_ENABLE)) begin
            irq_enable <= PWDATA[NUM_IRQ-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt source synchronisation and edge detection.
    // irq_meta/irq_sync form the two-flop synchroniser; irq_dly holds the
    // previous synchronised value. Resetting all three to 0 means a source
    // held high through reset release still yields exactly one edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            irq_meta <= '0;
            irq_sync <= '0;
            irq_dly  <= '0;
        end else begin
            irq_meta <= irq_in;
            irq_sync <= irq_meta;
            irq_dly  <= irq_sync;
        end
    end

    assign irq_edge = irq_sync & ~irq_dly;

    // -----------------------------------------------------------------------
    // Interrupt status: any set source (edge or IRQ_SET write) wins over a
    // W1C of the same bit in the same cycle.
    // -----------------------------------------------------------------------
    assign set_bits = (reg_wr && (reg_sel == SEL_IRQ_SET))    ? PWDATA[NUM_IRQ-1:0] : '0;
    assign w1c_bits = (reg_wr && (reg_sel == SEL_IRQ_STATUS)) ? PWDATA[NUM_IRQ-1:0] : '0;

    assign irq_status_nxt = irq_edge | set_bits | (irq_status & ~w1c_bits);

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            irq_status <= '0;
        end else begin
            irq_status <= irq_status_nxt;
        end
    end

    // Aggregate output is registered from the current status, so it trails a
    // status change by one edge.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_status & irq_enable);
        end
    end

endmodule

// File: tb/tb_apb_stream_irq_regs.sv
// ---------------------------------------------------------------------------
// Directed testbench for apb_stream_irq_regs (default parameters:
// ADDR_WIDTH 8, NUM_IRQ 8, 32-bit streams, TIMEOUT 15).
// ---------------------------------------------------------------------------
module tb_apb_stream_irq_regs;

    localparam int WAIT_LIMIT = 40;

    logic        RegClk;
    logic        RegReset;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  irq_in;
    logic        irq;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_hs   = 0;
    int          rd_hs   = 0;
    logic [31:0] last_wr_data = '0;

    apb_stream_irq_regs #(
        .ADDR_WIDTH (8),
        .NUM_IRQ    (8),
        .WDATA_WIDTH(32),
        .RDATA_WIDTH(32),
        .TIMEOUT    (15)
    ) dut (
        .RegClk  (RegClk),
        .RegReset(RegReset),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq_in  (irq_in),
        .irq     (irq),
        .wr_data (wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready)
    );

    initial RegClk = 1'b0;
    always #5 RegClk = ~RegClk;

    // Stream handshake monitor.
    always @(posedge RegClk) begin
        if (wr_valid && wr_ready) begin
            wr_hs        <= wr_hs + 1;
            last_wr_data <= wr_data;
        end
        if (rd_valid && rd_ready) begin
            rd_hs <= rd_hs + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One APB transfer. ready_at raises the stream partner (wr_ready for a
    // write, rd_valid for a read) after that many wait cycles; -1 = never.
    // Results are sampled in the completing access cycle.
    task automatic xfer(input logic [7:0] addr, input logic wr,
                        input logic [31:0] wdata, input int ready_at,
                        output logic [31:0] rdata, output logic err,
                        output int waits, output logic strobe);
        @(negedge RegClk);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        @(negedge RegClk);
        PENABLE = 1'b1;
        waits   = 0;
        if (ready_at == 0) begin
            if (wr) wr_ready = 1'b1; else rd_valid = 1'b1;
        end
        #1;
        while (!PREADY && waits < WAIT_LIMIT) begin
            @(negedge RegClk);
            waits++;
            if (waits == ready_at) begin
                if (wr) wr_ready = 1'b1; else rd_valid = 1'b1;
            end
            #1;
        end
        rdata  = PRDATA;
        err    = PSLVERR;
        strobe = wr ? wr_valid : rd_ready;
        @(posedge RegClk);
        #1;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
    endtask

    logic [31:0] rdata;
    logic        err;
    logic        strobe;
    int          waits;
    int          hs0;

    initial begin
        RegReset = 1'b1;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        irq_in   = '0;
        wr_ready = 1'b0;
        rd_data  = '0;
        rd_valid = 1'b0;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge RegClk);
        #1;
        check("rst_pready",  {31'd0, PREADY},   32'd1);
        check("rst_pslverr", {31'd0, PSLVERR},  32'd0);
        check("rst_prdata",  PRDATA,            32'd0);
        check("rst_irq",     {31'd0, irq},      32'd0);
        check("rst_wr_valid",{31'd0, wr_valid}, 32'd0);
        check("rst_wr_data", wr_data,           32'd0);
        check("rst_rd_ready",{31'd0, rd_ready}, 32'd0);
        @(negedge RegClk);
        RegReset = 1'b0;

        // ---------------- Reset mid-stream ----------------
        @(negedge RegClk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h0C; PWRITE = 1'b1; PWDATA = 32'h1111_2222;
        @(negedge RegClk);
        PENABLE = 1'b1;
        #1;
        check("mid_pready_stall", {31'd0, PREADY},   32'd0);
        check("mid_wr_valid",     {31'd0, wr_valid}, 32'd1);
        check("mid_wr_data",      wr_data,           32'h1111_2222);
        repeat (2) @(negedge RegClk);
        RegReset = 1'b1;
        #1;
        check("mid_rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("mid_rst_wr_data",  wr_data,           32'd0);
        check("mid_rst_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("mid_rst_pslverr",  {31'd0, PSLVERR},  32'd0);
        check("mid_rst_prdata",   PRDATA,            32'd0);
        check("mid_rst_irq",      {31'd0, irq},      32'd0);
        @(negedge RegClk);
        RegReset = 1'b0;
        // Access phase is still open: it restarts with wait_cnt = 0 and must
        // time out on its 16th access cycle.
        waits = 0;
        #1;
        while (!PREADY && waits < WAIT_LIMIT) begin
            @(negedge RegClk);
            waits++;
            #1;
        end
        check("mid_restart_waits", 32'(waits),        32'd15);
        check("mid_restart_err",   {31'd0, PSLVERR},  32'd1);
        check("mid_restart_valid", {31'd0, wr_valid}, 32'd0);
        @(posedge RegClk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("mid_no_handshake",  32'(wr_hs),        32'd0);

        xfer(8'h14, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("to_cnt_after_mid",  rdata, 32'h0000_0100);
        xfer(8'h14, 1'b1, 32'd0, -1, rdata, err, waits, strobe);
        check("to_cnt_clear_err",  {31'd0, err}, 32'd0);
        xfer(8'h14, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("to_cnt_cleared",    rdata, 32'd0);

        // ---------------- Register readback ----------------
        xfer(8'h04, 1'b1, 32'h0000_005A, -1, rdata, err, waits, strobe);
        check("en_wr_waits", 32'(waits), 32'd0);
        check("en_wr_err",   {31'd0, err}, 32'd0);
        xfer(8'h04, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("en_rd_data",  rdata, 32'h0000_005A);
        check("en_rd_waits", 32'(waits), 32'd0);

        // ---------------- Interrupt edge latency ----------------
        xfer(8'h04, 1'b1, 32'h0000_0001, -1, rdata, err, waits, strobe);
        @(negedge RegClk);
        irq_in[0] = 1'b1;
        @(posedge RegClk);                 // edge 1
        @(posedge RegClk);                 // edge 2
        #1;
        check("irq_e2_status", {24'd0, dut.irq_status}, 32'd0);
        @(posedge RegClk);                 // edge 3
        #1;
        check("irq_e3_status", {24'd0, dut.irq_status}, 32'h01);
        check("irq_e3_irq",    {31'd0, irq}, 32'd0);
        @(posedge RegClk);                 // edge 4
        #1;
        check("irq_e4_irq",    {31'd0, irq}, 32'd1);

        // W1C while the source is still high.
        xfer(8'h00, 1'b1, 32'h0000_0001, -1, rdata, err, waits, strobe);
        check("w1c_status",    {24'd0, dut.irq_status}, 32'd0);
        check("w1c_irq_hold",  {31'd0, irq}, 32'd1);
        @(posedge RegClk);
        #1;
        check("w1c_irq_fall",  {31'd0, irq}, 32'd0);
        repeat (3) @(posedge RegClk);
        xfer(8'h00, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("no_reset_edge", rdata, 32'd0);
        irq_in[0] = 1'b0;

        // ---------------- IRQ_SET and set-beats-clear ----------------
        xfer(8'h08, 1'b1, 32'h0000_0004, -1, rdata, err, waits, strobe);
        xfer(8'h08, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("irq_set_reads0", rdata, 32'd0);
        xfer(8'h00, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("irq_set_status", rdata, 32'h04);
        @(negedge RegClk);
        irq_in[2] = 1'b1;                  // edge 1 at next posedge
        @(negedge RegClk);                 // setup phase ends at edge 2
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'h04;
        @(negedge RegClk);                 // access phase ends at edge 3
        PENABLE = 1'b1;
        #1;
        check("sbc_pready", {31'd0, PREADY}, 32'd1);
        @(posedge RegClk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        xfer(8'h00, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("set_beats_clear", rdata, 32'h04);
        xfer(8'h00, 1'b1, 32'h0000_0004, -1, rdata, err, waits, strobe);
        xfer(8'h00, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("plain_w1c", rdata, 32'd0);
        irq_in[2] = 1'b0;

        // ---------------- Write stall ----------------
        hs0 = wr_hs;
        xfer(8'h0C, 1'b1, 32'hA5A5_A5A5, 3, rdata, err, waits, strobe);
        check("wstall_waits",  32'(waits), 32'd3);
        check("wstall_err",    {31'd0, err}, 32'd0);
        check("wstall_valid",  {31'd0, strobe}, 32'd1);
        check("wstall_hs",     32'(wr_hs - hs0), 32'd1);
        check("wstall_data",   last_wr_data, 32'hA5A5_A5A5);

        // ---------------- Read pop ----------------
        rd_data = 32'h1234_5678;
        hs0 = rd_hs;
        xfer(8'h10, 1'b0, 32'd0, 0, rdata, err, waits, strobe);
        check("pop_data",  rdata, 32'h1234_5678);
        check("pop_waits", 32'(waits), 32'd0);
        check("pop_err",   {31'd0, err}, 32'd0);
        check("pop_hs",    32'(rd_hs - hs0), 32'd1);

        // ---------------- Read timeout ----------------
        rd_data = 32'hDEAD_BEEF;
        hs0 = rd_hs;
        xfer(8'h10, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("rto_waits",  32'(waits), 32'd15);
        check("rto_err",    {31'd0, err}, 32'd1);
        check("rto_prdata", rdata, 32'd0);
        check("rto_ready",  {31'd0, strobe}, 32'd0);
        check("rto_no_hs",  32'(rd_hs - hs0), 32'd0);
        xfer(8'h14, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("rto_to_cnt", rdata, 32'h0000_0100);

        // ---------------- Handshake coincides with timeout ----------------
        hs0 = wr_hs;
        xfer(8'h0C, 1'b1, 32'h0BAD_F00D, 15, rdata, err, waits, strobe);
        check("prio_waits", 32'(waits), 32'd15);
        check("prio_err",   {31'd0, err}, 32'd1);
        check("prio_valid", {31'd0, strobe}, 32'd0);
        check("prio_no_hs", 32'(wr_hs - hs0), 32'd0);
        xfer(8'h14, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("prio_to_cnt", rdata, 32'h0000_0200);

        // ---------------- Unmapped address ----------------
        xfer(8'h20, 1'b1, 32'hFFFF_FFFF, -1, rdata, err, waits, strobe);
        check("unmap_waits", 32'(waits), 32'd0);
        check("unmap_err",   {31'd0, err}, 32'd1);
        xfer(8'h20, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("unmap_rd_data", rdata, 32'd0);
        check("unmap_rd_err",  {31'd0, err}, 32'd1);
        xfer(8'h04, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("unmap_enable_kept", rdata, 32'h01);
        xfer(8'h00, 1'b0, 32'd0, -1, rdata, err, waits, strobe);
        check("unmap_status_kept", rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
